// File: rtl/i2cmb_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the iicmb_m_wb slave port.
// Round-robin on ties, per-grant transfer limit with a drain cycle when the other master waits.
module i2cmb_wb_arbiter #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_irq_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_irq_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_irq_i,
  output logic [1:0]            gnt_o
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, DRAIN} state_t;

  state_t        state, state_nxt;
  logic          last_grant, last_grant_nxt;
  logic [CW-1:0] hold_cnt, hold_cnt_nxt;
  logic          sel0, sel1;
  logic          cur_cyc, oth_cyc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      hold_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      hold_cnt   <= hold_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    hold_cnt_nxt   = hold_cnt;
    cur_cyc        = (state == GNT1) ? m1_cyc_i : m0_cyc_i;
    oth_cyc        = (state == GNT1) ? m0_cyc_i : m1_cyc_i;
    case (state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_grant)) begin
          state_nxt      = GNT0;
          last_grant_nxt = 1'b0;
          hold_cnt_nxt   = '0;
        end else if (m1_cyc_i) begin
          state_nxt      = GNT1;
          last_grant_nxt = 1'b1;
          hold_cnt_nxt   = '0;
        end
      end
      GNT0, GNT1: begin
        if (!cur_cyc) begin
          state_nxt = IDLE;
        end else if (s_ack_i) begin
          if (hold_cnt != HOLD_MAX) hold_cnt_nxt = hold_cnt + CW'(1);
          // Once the limit is reached, every further ack is a release point if the other master waits.
          if (hold_cnt >= HOLD_LAST && oth_cyc) state_nxt = DRAIN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset gates the grant combinationally so no ack leaks in the reset cycle.
  assign sel0 = (state == GNT0) && !rst_i;
  assign sel1 = (state == GNT1) && !rst_i;

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    if (sel0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_cyc_i & m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (sel1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_cyc_i & m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  assign m0_ack_o = sel0 & s_ack_i;
  assign m1_ack_o = sel1 & s_ack_i;
  assign m0_dat_o = sel0 ? s_dat_i : '0;
  assign m1_dat_o = sel1 ? s_dat_i : '0;
  assign m0_irq_o = s_irq_i;
  assign m1_irq_o = s_irq_i;
  assign gnt_o    = {sel1, sel0};

endmodule

// File: tb/tb_i2cmb_wb_arbiter.sv
// Scoreboard bench for i2cmb_wb_arbiter: directed scenarios then random traffic, checked per cycle.
module tb_i2cmb_wb_arbiter;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int MAXH = 4;

  typedef struct {
    logic                  rst;
    logic [1:0]            cyc, stb, we;
    logic [1:0][AW-1:0]    adr;
    logic [1:0][DW-1:0]    dat;
    logic [DW-1:0]         sdat;
    logic                  ack, irq;
  } stim_t;

  typedef struct {
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat;
    logic [1:0]    ack;
    logic [1:0][DW-1:0] mdat;
    logic          irq;
    logic [1:0]    gnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  stim_t cur, prev, s;
  exp_t  expq[$];
  int    checks = 0;
  int    errors = 0;
  int    drains = 0;

  // Reference state: who holds the bus (-1 = nobody), drain pending, last winner, acks taken.
  int m_grant = -1;
  bit m_drain = 0;
  int m_last  = 1;
  int m_held  = 0;

  logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o;
  logic [AW-1:0] s_adr_o;
  logic m0_ack_o, m0_irq_o, m1_ack_o, m1_irq_o, s_cyc_o, s_stb_o, s_we_o;
  logic [1:0] gnt_o;

  i2cmb_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MAXH)) dut (
    .clk_i(clk), .rst_i(cur.rst),
    .m0_cyc_i(cur.cyc[0]), .m0_stb_i(cur.stb[0]), .m0_we_i(cur.we[0]),
    .m0_adr_i(cur.adr[0]), .m0_dat_i(cur.dat[0]), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_irq_o(m0_irq_o),
    .m1_cyc_i(cur.cyc[1]), .m1_stb_i(cur.stb[1]), .m1_we_i(cur.we[1]),
    .m1_adr_i(cur.adr[1]), .m1_dat_i(cur.dat[1]), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_irq_o(m1_irq_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(cur.sdat), .s_ack_i(cur.ack), .s_irq_i(cur.irq),
    .gnt_o(gnt_o)
  );

  function automatic stim_t idle_stim();
    stim_t t;
    t.rst = 1'b0; t.cyc = '0; t.stb = '0; t.we = '0;
    t.adr = '0; t.dat = '0; t.sdat = '0; t.ack = 1'b0; t.irq = 1'b0;
    return t;
  endfunction

  // Advance the reference by one clock edge using the inputs held during the past cycle.
  task automatic advance(input stim_t p);
    int pick;
    if (p.rst) begin
      m_grant = -1; m_drain = 0; m_last = 1; m_held = 0;
    end else if (m_drain) begin
      m_drain = 0;
    end else if (m_grant < 0) begin
      pick = -1;
      if (p.cyc[0] && p.cyc[1]) pick = 1 - m_last;
      else if (p.cyc[0])        pick = 0;
      else if (p.cyc[1])        pick = 1;
      if (pick >= 0) begin
        m_grant = pick; m_last = pick; m_held = 0;
      end
    end else if (!p.cyc[m_grant]) begin
      m_grant = -1;
    end else if (p.ack) begin
      m_held = (m_held < MAXH) ? m_held + 1 : MAXH;
      if (m_held == MAXH && p.cyc[1 - m_grant]) begin
        m_grant = -1; m_drain = 1; drains++;
      end
    end
  endtask

  function automatic exp_t predict(input stim_t t);
    exp_t e;
    bit   act;
    int   g;
    act = !t.rst && (m_grant >= 0);
    g   = (m_grant >= 0) ? m_grant : 0;
    e.s_cyc = act ? t.cyc[g] : 1'b0;
    e.s_stb = act ? (t.cyc[g] & t.stb[g]) : 1'b0;
    e.s_we  = act ? t.we[g] : 1'b0;
    e.s_adr = act ? t.adr[g] : '0;
    e.s_dat = act ? t.dat[g] : '0;
    e.ack   = '0;
    e.mdat  = '0;
    e.gnt   = '0;
    if (act) begin
      e.ack[g]  = t.ack;
      e.mdat[g] = t.sdat;
      e.gnt[g]  = 1'b1;
    end
    e.irq = t.irq;
    return e;
  endfunction

  task automatic step(input stim_t t);
    @(posedge clk); #1;
    advance(prev);
    prev = t;
    cur  = t;
    expq.push_back(predict(t));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("s_cyc", 32'(s_cyc_o), 32'(e.s_cyc));
        chk("s_stb", 32'(s_stb_o), 32'(e.s_stb));
        chk("s_we", 32'(s_we_o), 32'(e.s_we));
        chk("s_adr", 32'(s_adr_o), 32'(e.s_adr));
        chk("s_dat", 32'(s_dat_o), 32'(e.s_dat));
        chk("m0_ack", 32'(m0_ack_o), 32'(e.ack[0]));
        chk("m1_ack", 32'(m1_ack_o), 32'(e.ack[1]));
        chk("m0_dat", 32'(m0_dat_o), 32'(e.mdat[0]));
        chk("m1_dat", 32'(m1_dat_o), 32'(e.mdat[1]));
        chk("m0_irq", 32'(m0_irq_o), 32'(e.irq));
        chk("m1_irq", 32'(m1_irq_o), 32'(e.irq));
        chk("gnt", 32'(gnt_o), 32'(e.gnt));
        chk("stb_implies_cyc", 32'(s_stb_o & ~s_cyc_o), 32'd0);
      end
    end
  end

  initial begin
    s = idle_stim();
    s.rst = 1'b1;
    cur = s; prev = s;
    step(s); step(s);
    s.rst = 1'b0;
    step(s);

    // m0 write adr=2 dat=0x05, slave acks on the second cycle of the grant
    s.cyc[0] = 1; s.stb[0] = 1; s.we[0] = 1; s.adr[0] = 2; s.dat[0] = 8'h05;
    step(s); step(s);
    s.ack = 1; step(s);
    s.ack = 0; s = idle_stim(); step(s); step(s);

    // tie: m0 wins (last_grant was m0 now, so check both ordering cases next)
    s.rst = 1; step(s); s.rst = 0; step(s);
    s.cyc = 2'b11; s.stb = 2'b11; s.we = 2'b01; s.adr[1] = 1;
    step(s); s.ack = 1; s.sdat = 8'h80; step(s); s.ack = 0; step(s);
    s.cyc[0] = 0; s.stb[0] = 0; step(s); step(s);
    // m1 read of 0x80
    s.ack = 1; step(s); s.ack = 0; step(s);
    s = idle_stim(); step(s); step(s);

    // m0 holds for 10 acks while m1 waits: drain after the 4th
    s.cyc = 2'b11; s.stb = 2'b11; s.we = 2'b01;
    step(s);
    s.ack = 1;
    for (int i = 0; i < 10; i++) begin
      s.sdat = 8'(i); step(s);
    end
    s = idle_stim(); step(s); step(s);

    // m0 alone past the limit: grant holds, count saturates
    s.cyc[0] = 1; s.stb[0] = 1; step(s);
    s.ack = 1;
    for (int i = 0; i < 7; i++) step(s);
    s.cyc[1] = 1; step(s); step(s); step(s);
    s = idle_stim(); step(s); step(s);

    // reset pulse mid m1 read, then a tie goes to m0
    s.cyc[1] = 1; s.stb[1] = 1; s.adr[1] = 1; step(s); step(s);
    s.ack = 1; s.sdat = 8'h3c; step(s);
    s.rst = 1; step(s);
    s.rst = 0; s.ack = 0; s.cyc = 2'b11; s.stb = 2'b11; step(s); step(s); step(s);
    s = idle_stim(); step(s); step(s);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) s.cyc[0] = ~s.cyc[0];
      if ($urandom_range(7) == 0) s.cyc[1] = ~s.cyc[1];
      s.stb  = 2'($urandom);
      s.we   = 2'($urandom);
      s.adr  = 4'($urandom);
      s.dat  = 16'($urandom);
      s.sdat = 8'($urandom);
      s.ack  = 1'($urandom);
      s.irq  = 1'($urandom);
      s.rst  = ($urandom_range(99) == 0);
      step(s);
    end
    s = idle_stim(); step(s);
    @(negedge clk); #1;
    chk("queue_drained", 32'(expq.size()), 32'd0);
    if (drains == 0) chk("drain_exercised", 32'(drains), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2cmb_wb_arbiter.md
I2CMB_WB_ARBITER -- requirements
Module: i2cmb_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 2, Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, Wishbone data width.
REQ-003 SHALL have parameter MAX_HOLD, default 64, maximum number of acked transfers one grant may carry.
REQ-004 SHALL have clk_i  in  1  system clock; the single clock for the block.
REQ-005 SHALL have rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have m0_cyc_i  in  1  master 0 bus cycle valid.
REQ-007 SHALL have m0_stb_i  in  1  master 0 strobe.
REQ-008 SHALL have m0_we_i  in  1  master 0 write enable.
REQ-009 SHALL have m0_adr_i  in  ADDR_WIDTH  master 0 address.
REQ-010 SHALL have m0_dat_i  in  DATA_WIDTH  master 0 write data.
REQ-011 SHALL have m0_dat_o  out  DATA_WIDTH  master 0 read data.
REQ-012 SHALL have m0_ack_o  out  1  master 0 acknowledge.
REQ-013 SHALL have m0_irq_o  out  1  master 0 interrupt.
REQ-014 SHALL have m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_dat_o, m1_ack_o and m1_irq_o, identical to the m0 set, for master 1.
REQ-015 SHALL have s_cyc_o, s_stb_o and s_we_o  out  1 each  slave (iicmb_m_wb) cycle, strobe and write enable.
REQ-016 SHALL have s_adr_o  out  ADDR_WIDTH  and s_dat_o  out  DATA_WIDTH  slave address and write data.
REQ-017 SHALL have s_dat_i  in  DATA_WIDTH, s_ack_i  in  1 and s_irq_i  in  1  slave read data, acknowledge and interrupt.
REQ-018 SHALL have gnt_o  out  2  one-hot current grant; 00 means idle.

Function
REQ-019 SHALL implement states IDLE, GNT0, GNT1 and DRAIN.
REQ-020 IDLE: with only mN_cyc_i high, SHALL enter GNTN on the next clk_i edge.
REQ-021 IDLE with both cyc high: SHALL grant the master not in last_grant (round robin), then update last_grant.
REQ-022 Grant latency SHALL be exactly 1 cycle from mN_cyc_i rising to s_cyc_o high.
REQ-023 In GNTN, s_cyc/stb/we/adr/dat_o SHALL combinationally equal master N's inputs.
REQ-024 In GNTN, mN_ack_o SHALL equal s_ack_i and mN_dat_o SHALL equal s_dat_i.
REQ-025 The non-granted master SHALL see ack 0 and dat_o 0 at all times.
REQ-026 In IDLE and DRAIN, all s_* outputs SHALL be 0.
REQ-027 GNTN to IDLE: when mN_cyc_i is low, the next cycle SHALL be IDLE, giving 1 dead cycle before the next grant.
REQ-028 hold_cnt (width clog2(MAX_HOLD+1)) SHALL clear on grant and increment on each s_ack_i in GNTN.
REQ-029 When hold_cnt reaches MAX_HOLD and the other master's cyc is high, SHALL enter DRAIN after that ack.
REQ-030 DRAIN SHALL force s_cyc_o low; DRAIN to IDLE after 1 cycle; last_grant=N, so the other master wins the tie.
REQ-031 When hold_cnt reaches MAX_HOLD and the other master is idle, the grant SHALL continue and hold_cnt SHALL saturate.
REQ-032 s_stb_o SHALL never assert without s_cyc_o.
REQ-033 An ack arriving in IDLE or DRAIN SHALL be dropped.
REQ-034 m0_irq_o and m1_irq_o SHALL both equal s_irq_i, unregistered.
REQ-035 gnt_o SHALL be 01 in GNT0, 10 in GNT1, and 00 otherwise.

Reset
REQ-036 While rst_i is sampled high: state=IDLE, last_grant=1, hold_cnt=0, gnt_o=00, all s_* and m*_ack_o/dat_o 0.
REQ-037 Reset asserted mid-transfer SHALL abort the grant at that edge with no ack forwarded; the first tie after reset SHALL go to m0.

Verification
REQ-038 Reset, then m0 writes adr=2 dat=0x05 -> s_cyc_o high 1 cycle after m0_cyc_i, s_adr_o=2, s_dat_o=0x05, m0_ack_o=s_ack_i, gnt_o=01.
REQ-039 m0 and m1 raise cyc in the same cycle after reset -> m0 granted first; m1 granted 2 cycles after m0 drops cyc; gnt_o=10.
REQ-040 m1 reads adr=1 while slave drives 0x80 -> m1_dat_o=0x80, m0_dat_o=0x00, m0_ack_o=0.
REQ-041 MAX_HOLD=4; m0 holds cyc for 10 transfers while m1 requests -> after the 4th ack: DRAIN 1 cycle, IDLE 1 cycle, then GNT1.
REQ-042 rst_i pulsed 1 cycle during an m1 read -> next cycle gnt_o=00, s_cyc_o=0, no m1_ack_o; a subsequent tie is granted to m0.
